// File: rtl/led_frame_sequencer.sv
// Frame-rate scheduler: buffers host brightness words in a small FIFO and
// hands exactly one word to LEDControl per PWM frame, only on frame boundaries.
// Optional build macro: UNDERRUN_BLANK_EN (underrun blanks LED instead of holding).
// Ports:
//   clk, globalReset          clock, synchronous active-high reset
//   hostData/hostValid/Ready  valid/ready push interface from host
//   enable                    1 = sequence frames, 0 = idle
//   LEDFrameData              registered brightness to LEDControl
//   frameStart                pulse in first cycle of each new frame
//   fifoLevel                 FIFO occupancy
//   underrunCount             saturating count of empty-FIFO boundaries
module led_frame_sequencer #(
    parameter int DATA_W       = 12,
    parameter int FRAME_CYCLES = 4096,
    parameter int FIFO_DEPTH   = 4,
    parameter int UCNT_W       = 8
) (
    input  logic                        clk,
    input  logic                        globalReset,
    input  logic [DATA_W-1:0]           hostData,
    input  logic                        hostValid,
    output logic                        hostReady,
    input  logic                        enable,
    output logic [DATA_W-1:0]           LEDFrameData,
    output logic                        frameStart,
    output logic [$clog2(FIFO_DEPTH):0] fifoLevel,
    output logic [UCNT_W-1:0]           underrunCount
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FRAME_CYCLES);
    localparam logic [CW-1:0] LAST  = CW'(FRAME_CYCLES - 1);
    localparam logic [AW:0]   DEPTH = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [CW-1:0]     r_frame_cnt;
    logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]     r_wptr;
    logic [AW-1:0]     r_rptr;
    logic [AW:0]       r_level;
    logic [DATA_W-1:0] r_led;
    logic              r_frame_start;
    logic [UCNT_W-1:0] r_ucnt;

    logic w_start;
    logic w_stop;
    logic w_boundary;
    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;
    logic w_underrun;

    always_comb begin
        w_next     = r_state;
        w_start    = 1'b0;
        w_stop     = 1'b0;
        w_boundary = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (enable) begin
                    w_next  = RUN;
                    w_start = 1'b1;
                end
            end
            RUN: begin
                // Dropping enable wins over a coinciding boundary.
                if (!enable) begin
                    w_next = IDLE;
                    w_stop = 1'b1;
                end else if (r_frame_cnt == LAST) begin
                    w_boundary = 1'b1;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    assign w_full     = (r_level == DEPTH);
    assign w_empty    = (r_level == '0);
    assign w_push     = hostValid && !w_full;
    // Pop decision uses pre-edge occupancy: a word pushed on an empty
    // boundary is stored, never bypassed to the output.
    assign w_pop      = w_boundary && !w_empty;
    assign w_underrun = w_boundary && w_empty;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= hostData;
        end
    end

    always_ff @(posedge clk) begin
        if (globalReset) begin
            r_state       <= IDLE;
            r_frame_cnt   <= '0;
            r_wptr        <= '0;
            r_rptr        <= '0;
            r_level       <= '0;
            r_led         <= '0;
            r_frame_start <= 1'b0;
            r_ucnt        <= '0;
        end else begin
            r_state       <= w_next;
            r_frame_start <= w_boundary;

            // Loading LAST on entry puts the first boundary on the next edge.
            if (w_start) begin
                r_frame_cnt <= LAST;
            end else if (w_stop || r_state == IDLE) begin
                r_frame_cnt <= '0;
            end else if (r_frame_cnt == LAST) begin
                r_frame_cnt <= '0;
            end else begin
                r_frame_cnt <= r_frame_cnt + 1'b1;
            end

            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_level <= r_level + 1'b1;
            end else if (!w_push && w_pop) begin
                r_level <= r_level - 1'b1;
            end

            if (w_stop) begin
                r_led <= '0;
            end else if (w_pop) begin
                r_led <= r_mem[r_rptr];
            end else if (w_underrun) begin
`ifdef UNDERRUN_BLANK_EN
                r_led <= '0;
`else
                r_led <= r_led;
`endif
            end

            if (w_underrun && r_ucnt != '1) begin
                r_ucnt <= r_ucnt + 1'b1;
            end
        end
    end

    assign hostReady     = !w_full;
    assign LEDFrameData  = r_led;
    assign frameStart    = r_frame_start;
    assign fifoLevel     = r_level;
    assign underrunCount = r_ucnt;

endmodule

// File: tb/tb_led_frame_sequencer.sv
// Self-checking bench for led_frame_sequencer (FRAME_CYCLES=16, FIFO_DEPTH=4).
// Directed scenarios plus randomized traffic against a queue-based model.
module tb_led_frame_sequencer;
    localparam int DW = 12;
    localparam int FC = 16;
    localparam int FD = 4;
    localparam int UW = 8;
    localparam int UMAX = (1 << UW) - 1;

    logic          clk = 1'b0;
    logic          globalReset;
    logic [DW-1:0] hostData;
    logic          hostValid;
    logic          hostReady;
    logic          enable;
    logic [DW-1:0] LEDFrameData;
    logic          frameStart;
    logic [2:0]    fifoLevel;
    logic [UW-1:0] underrunCount;

    always #5 clk = ~clk;

    led_frame_sequencer #(
        .DATA_W      (DW),
        .FRAME_CYCLES(FC),
        .FIFO_DEPTH  (FD),
        .UCNT_W      (UW)
    ) dut (
        .clk          (clk),
        .globalReset  (globalReset),
        .hostData     (hostData),
        .hostValid    (hostValid),
        .hostReady    (hostReady),
        .enable       (enable),
        .LEDFrameData (LEDFrameData),
        .frameStart   (frameStart),
        .fifoLevel    (fifoLevel),
        .underrunCount(underrunCount)
    );

    int errs   = 0;
    int checks = 0;

    // Model: FIFO as a queue, boundaries as absolute edge indices.
    int q[$];
    int pend[$];
    bit m_run;
    int t;
    int nb;
    int m_led;
    int m_ucnt;
    bit m_fs;
    int gap_pct;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s edge=%0d got=%0d exp=%0d", tag, t, got, exp);
        end
    endtask

    task automatic drive();
        if (pend.size() > 0 &&
            (gap_pct == 0 || int'($urandom_range(99)) >= gap_pct)) begin
            hostValid = 1'b1;
            hostData  = DW'(pend[0]);
        end else begin
            hostValid = 1'b0;
            hostData  = DW'($urandom);
        end
    endtask

    task automatic step();
        bit rdy;
        bit bnd;
        @(posedge clk);
        rdy = q.size() < FD;
        if (globalReset) begin
            q.delete();
            m_run  = 1'b0;
            m_led  = 0;
            m_fs   = 1'b0;
            m_ucnt = 0;
        end else begin
            bnd  = m_run && enable && (t == nb);
            m_fs = bnd;
            if (m_run && !enable) begin
                m_run = 1'b0;
                m_led = 0;
            end else if (!m_run && enable) begin
                m_run = 1'b1;
                nb    = t + 1;
            end
            if (bnd) begin
                nb = nb + FC;
                if (q.size() > 0) begin
                    m_led = q.pop_front();
                end else begin
                    if (m_ucnt < UMAX) m_ucnt++;
`ifdef UNDERRUN_BLANK_EN
                    m_led = 0;
`endif
                end
            end
            if (hostValid && rdy) begin
                q.push_back(int'(hostData));
                void'(pend.pop_front());
            end
        end
        t++;
        #1;
        chk("led",   32'(LEDFrameData),  32'(m_led));
        chk("fs",    32'(frameStart),    32'(m_fs));
        chk("level", 32'(fifoLevel),     32'(q.size()));
        chk("ucnt",  32'(underrunCount), 32'(m_ucnt));
        chk("ready", 32'(hostReady),     32'(q.size() < FD));
        @(negedge clk);
        drive();
    endtask

    task automatic run(int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        globalReset = 1'b1;
        enable      = 1'b0;
        step();
        globalReset = 1'b0;
    endtask

    initial begin
        globalReset = 1'b1;
        enable      = 1'b0;
        hostValid   = 1'b0;
        hostData    = '0;
        gap_pct     = 0;
        t           = 0;
        nb          = 0;
        m_run       = 1'b0;
        m_led       = 0;
        m_ucnt      = 0;
        m_fs        = 1'b0;
        @(negedge clk);
        step();
        step();
        globalReset = 1'b0;

        // Three words then a 16-cycle cadence, then underruns.
        pend = '{4094, 5, 8};
        drive();
        run(4);
        enable = 1'b1;
        run(70);

        // Six words while idle: back-pressure after four.
        do_reset();
        pend = '{11, 22, 33, 44, 55, 66};
        drive();
        run(10);
        enable = 1'b1;
        run(120);

        // Drain to empty after 10 and saturate the underrun counter.
        do_reset();
        pend = '{10};
        drive();
        enable = 1'b1;
        run(FC * (UMAX + 4));

        // Push 3000 exactly on a boundary with an empty FIFO.
        for (int k = 0; k < 2 * FC && t != nb; k++) step();
        pend.push_back(3000);
        drive();
        step();
        run(2 * FC + 4);

        // Drop enable at frameCnt=7 with entries retained.
        pend = '{100, 200, 300, 400};
        drive();
        run(FC + 6);
        for (int k = 0; k < 2 * FC && t != nb - 8; k++) step();
        enable = 1'b0;
        step();
        run(5);
        enable = 1'b1;
        run(5 * FC);

        // Reset mid-run with entries queued.
        pend = '{1, 2, 3, 4};
        drive();
        run(6);
        globalReset = 1'b1;
        step();
        globalReset = 1'b0;
        pend.delete();
        drive();
        run(2 * FC);

        // Randomized traffic.
        gap_pct = 40;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(99) < 3) enable = ~enable;
            globalReset = ($urandom_range(699) == 0);
            if (pend.size() < 2 && $urandom_range(99) < 20) begin
                pend.push_back(int'($urandom_range((1 << DW) - 1)));
                drive();
            end
            step();
        end
        globalReset = 1'b0;

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
